// File: rtl/aca_pkg.sv
// Shared types and helpers for the block-speculative ACA-CSU adder controller.
// Provides the datapath geometry, the controller state encoding, per-block
// propagate/generate reduction and the speculative inter-block carry vector.
package aca_pkg;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned BLK   = 4;
  localparam int unsigned NBLK  = WIDTH / BLK;
  localparam int unsigned FIXW  = (NBLK > 1) ? $clog2(NBLK) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    OUT   = 2'd2
  } state_e;

  // Block propagate/generate with carry-in 0; returns {P, G}.
  function automatic logic [1:0] blk_pg(input logic [BLK-1:0] p,
                                        input logic [BLK-1:0] g);
    logic pp;
    logic gg;
    pp = 1'b1;
    gg = 1'b0;
    for (int i = 0; i < int'(BLK); i++) begin
      gg = g[i] | (p[i] & gg);
      pp = pp & p[i];
    end
    return {pp, gg};
  endfunction

  // Speculative carry into each block; a fully propagating block k-1 takes the
  // top-bit generate of block k-2 instead of its own (zero) generate.
  function automatic logic [NBLK-1:0] spec_carry(input logic [WIDTH-1:0] p,
                                                 input logic [WIDTH-1:0] g);
    logic [NBLK-1:0] c;
    logic [1:0]      pg;
    int              idx;
    c = '0;
    for (int k = 1; k < int'(NBLK); k++) begin
      pg  = blk_pg(p[(k-1)*int'(BLK) +: BLK], g[(k-1)*int'(BLK) +: BLK]);
      idx = (k >= 2) ? ((k - 1) * int'(BLK) - 1) : 0;
      if (k == 1) c[k] = pg[0];
      else        c[k] = pg[1] ? g[idx] : pg[0];
    end
    return c;
  endfunction

endpackage

// File: rtl/aca_blk_eval.sv
// Combinational per-block evaluation for the current carry vector.
// Ports: p_i/g_i bitwise propagate/generate, c_i carry into each block;
// sum_o block sums, cout_o block carry-outs, mis_o per-block carry mismatch,
// mis_idx_o lowest mismatching block (0 when none).
module aca_blk_eval
  import aca_pkg::*;
(
  input  logic [WIDTH-1:0] p_i,
  input  logic [WIDTH-1:0] g_i,
  input  logic [NBLK-1:0]  c_i,
  output logic [WIDTH-1:0] sum_o,
  output logic [NBLK-1:0]  cout_o,
  output logic [NBLK-1:0]  mis_o,
  output logic [FIXW-1:0]  mis_idx_o
);

  // Ripple within each block from its assumed carry-in.
  always_comb begin : blk_sum
    logic cr;
    sum_o  = '0;
    cout_o = '0;
    cr     = 1'b0;
    for (int k = 0; k < int'(NBLK); k++) begin
      cr = c_i[k];
      for (int i = 0; i < int'(BLK); i++) begin
        sum_o[k*int'(BLK) + i] = p_i[k*int'(BLK) + i] ^ cr;
        cr = g_i[k*int'(BLK) + i] | (p_i[k*int'(BLK) + i] & cr);
      end
      cout_o[k] = cr;
    end
  end

  // Block 0 always has the true carry-in (0), so it can never mismatch.
  always_comb begin : blk_mis
    mis_o     = '0;
    mis_idx_o = '0;
    for (int k = 1; k < int'(NBLK); k++) begin
      mis_o[k] = c_i[k] ^ cout_o[k-1];
    end
    for (int k = int'(NBLK) - 1; k >= 1; k--) begin
      if (mis_o[k]) mis_idx_o = FIXW'(k);
    end
  end

endmodule

// File: rtl/aca_vla_ctrl.sv
// Variable-latency controller around the speculative ACA-CSU adder.
// Ports: in_valid/in_ready/a/b/exact operand handshake; out_valid/out_ready
// result handshake with sum (MSB = carry out), err, fix_cnt; clear_stats and
// saturating ops_cnt/err_cnt statistics.
module aca_vla_ctrl
  import aca_pkg::*;
#(
  parameter int unsigned CNTW = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             exact,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic             err,
  output logic [FIXW-1:0]  fix_cnt,
  input  logic             clear_stats,
  output logic [CNTW-1:0]  ops_cnt,
  output logic [CNTW-1:0]  err_cnt
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             exact_q, exact_d;
  logic [NBLK-1:0]  carry_q, carry_d;
  logic [FIXW-1:0]  fix_q, fix_d;
  logic             err_q, err_d;
  logic [WIDTH:0]   sum_q, sum_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [CNTW-1:0]  ops_q, ops_d, errc_q, errc_d;

  logic [WIDTH-1:0] bsum;
  logic [NBLK-1:0]  bcout, mis;
  logic [FIXW-1:0]  mis_idx;
  logic             mis_any;
  logic             done;

  aca_blk_eval u_eval (
    .p_i       (a_q ^ b_q),
    .g_i       (a_q & b_q),
    .c_i       (carry_q),
    .sum_o     (bsum),
    .cout_o    (bcout),
    .mis_o     (mis),
    .mis_idx_o (mis_idx)
  );

  assign mis_any = |mis;

  // Next-state, datapath and statistics update.
  always_comb begin : fsm_next
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    exact_d     = exact_q;
    carry_d     = carry_q;
    fix_d       = fix_q;
    err_d       = err_q;
    sum_d       = sum_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    ops_d       = ops_q;
    errc_d      = errc_q;
    done        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d        = a;
          b_d        = b;
          exact_d    = exact;
          carry_d    = spec_carry(a ^ b, a & b);
          fix_d      = '0;
          err_d      = 1'b0;
          in_ready_d = 1'b0;
          state_d    = CHECK;
        end
      end
      CHECK: begin
        if (mis_any) err_d = 1'b1;
        // Lower blocks are already consistent, so the fixed carry is exact.
        if (exact_q && mis_any) begin
          carry_d[mis_idx] = bcout[mis_idx - FIXW'(1)];
          fix_d            = fix_q + FIXW'(1);
        end else begin
          sum_d       = {bcout[NBLK-1], bsum};
          out_valid_d = 1'b1;
          state_d     = OUT;
        end
      end
      OUT: begin
        if (out_ready) begin
          done        = 1'b1;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Clear wins over a same-cycle completion.
    if (clear_stats) begin
      ops_d  = '0;
      errc_d = '0;
    end else if (done) begin
      if (ops_q != '1)            ops_d  = ops_q + CNTW'(1);
      if (err_q && errc_q != '1)  errc_d = errc_q + CNTW'(1);
    end
  end

  // State and data registers.
  always_ff @(posedge clk or posedge rst) begin : regs
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      exact_q     <= 1'b0;
      carry_q     <= '0;
      fix_q       <= '0;
      err_q       <= 1'b0;
      sum_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      ops_q       <= '0;
      errc_q      <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      exact_q     <= exact_d;
      carry_q     <= carry_d;
      fix_q       <= fix_d;
      err_q       <= err_d;
      sum_q       <= sum_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      ops_q       <= ops_d;
      errc_q      <= errc_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign err       = err_q;
  assign fix_cnt   = fix_q;
  assign ops_cnt   = ops_q;
  assign err_cnt   = errc_q;

endmodule

// File: tb/tb_aca_vla_ctrl.sv
// Self-checking bench for aca_vla_ctrl: scoreboard of expected results, plus a
// narrow-counter instance sharing the stimulus to reach counter saturation.
module tb_aca_vla_ctrl;
  import aca_pkg::*;

  typedef struct {
    logic [WIDTH:0] sum;
    logic           err;
    int             fix;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   exp_ops = 0, exp_errc = 0, s_ops = 0, s_errc = 0;

  logic             clk, rst;
  logic             in_valid, exact, out_ready, clear_stats;
  logic [WIDTH-1:0] a, b;
  logic             in_ready, out_valid, err;
  logic [WIDTH:0]   sum;
  logic [FIXW-1:0]  fix_cnt;
  logic [15:0]      ops_cnt, err_cnt;
  logic             in_ready_s, out_valid_s, err_s;
  logic [WIDTH:0]   sum_s;
  logic [FIXW-1:0]  fix_cnt_s;
  logic [3:0]       ops_cnt_s, err_cnt_s;

  aca_vla_ctrl u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .exact(exact), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .err(err), .fix_cnt(fix_cnt), .clear_stats(clear_stats),
    .ops_cnt(ops_cnt), .err_cnt(err_cnt)
  );

  aca_vla_ctrl #(.CNTW(4)) u_dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
    .a(a), .b(b), .exact(exact), .out_valid(out_valid_s), .out_ready(out_ready),
    .sum(sum_s), .err(err_s), .fix_cnt(fix_cnt_s), .clear_stats(clear_stats),
    .ops_cnt(ops_cnt_s), .err_cnt(err_cnt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference: speculative carries from the adder definition, true carries
  // from a full-width add; exact mode needs one fix per wrong carry.
  function automatic void ref_op(input logic [15:0] av, input logic [15:0] bv,
                                 input logic ex, output logic [16:0] s,
                                 output logic e, output int f);
    logic [3:0]  spec, tru;
    logic [4:0]  t;
    logic [16:0] full;
    int          idx;
    spec = '0;
    tru  = '0;
    s    = '0;
    full = {1'b0, av} + {1'b0, bv};
    for (int k = 1; k < 4; k++) begin
      t = {1'b0, av[(k-1)*4 +: 4]} + {1'b0, bv[(k-1)*4 +: 4]};
      if (k == 1) spec[k] = t[4];
      else begin
        idx = (k - 1) * 4 - 1;
        spec[k] = ((av[(k-1)*4 +: 4] ^ bv[(k-1)*4 +: 4]) == 4'hF) ? (av[idx] & bv[idx]) : t[4];
      end
      tru[k] = full[k*4] ^ av[k*4] ^ bv[k*4];
    end
    e = (spec != tru);
    f = ex ? $countones(spec ^ tru) : 0;
    if (ex) s = full;
    else begin
      for (int k = 0; k < 4; k++) begin
        t = {1'b0, av[k*4 +: 4]} + {1'b0, bv[k*4 +: 4]} + {4'b0, spec[k]};
        s[k*4 +: 4] = t[3:0];
        if (k == 3) s[16] = t[4];
      end
    end
  endfunction

  task automatic stat_upd(input logic e, input logic clr);
    if (clr) begin
      exp_ops = 0; exp_errc = 0; s_ops = 0; s_errc = 0;
    end else begin
      exp_ops++;
      if (e) exp_errc++;
      if (s_ops < 15) s_ops++;
      if (e && s_errc < 15) s_errc++;
    end
  endtask

  task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input logic ex,
                        input logic [16:0] es, input logic ee, input int ef,
                        input int hold, input logic clr);
    exp_t        x, y;
    int          n;
    logic [16:0] s0;
    x.sum = es; x.err = ee; x.fix = ef;
    sb_q.push_back(x);
    @(negedge clk);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    a = av; b = bv; exact = ex; in_valid = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (n < 20) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (out_valid) break;
    end
    y = sb_q.pop_front();
    chk("out_valid", 32'(out_valid), 32'd1);
    chk("latency", 32'(n), 32'(1 + y.fix));
    chk("sum", 32'(sum), 32'(y.sum));
    chk("err", 32'(err), 32'(y.err));
    chk("fix_cnt", 32'(fix_cnt), 32'(y.fix));
    if (hold > 0) begin
      s0 = sum;
      in_valid = 1'b1; a = 16'h1234; b = 16'h4321;
      repeat (hold) begin
        @(negedge clk);
        chk("bp_sum", 32'(sum), 32'(s0));
        chk("bp_err", 32'(err), 32'(y.err));
        chk("bp_valid", 32'(out_valid), 32'd1);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
    end
    clear_stats = clr;
    @(posedge clk); #1;
    clear_stats = 1'b0;
    stat_upd(y.err, clr);
    chk("ops_cnt", 32'(ops_cnt), 32'(exp_ops));
    chk("err_cnt", 32'(err_cnt), 32'(exp_errc));
    chk("ops_cnt_s", 32'(ops_cnt_s), 32'(s_ops));
    chk("err_cnt_s", 32'(err_cnt_s), 32'(s_errc));
    chk("valid_drop", 32'(out_valid), 32'd0);
    chk("ready_back", 32'(in_ready), 32'd1);
  endtask

  task automatic rand_op(input logic [15:0] av, input logic [15:0] bv, input logic ex);
    logic [16:0] s;
    logic        e;
    int          f;
    ref_op(av, bv, ex, s, e, f);
    run_op(av, bv, ex, s, e, f, 0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; exact = 1'b0; out_ready = 1'b1;
    clear_stats = 1'b0; a = '0; b = '0;
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_ops", 32'(ops_cnt), 32'd0);
    @(negedge clk); rst = 1'b0;

    // Directed vectors.
    run_op(16'h0001, 16'h0002, 1'b1, 17'h00003, 1'b0, 0, 0, 1'b0);
    run_op(16'h00FF, 16'h0001, 1'b0, 17'h00000, 1'b1, 0, 0, 1'b0);
    run_op(16'h00FF, 16'h0001, 1'b1, 17'h00100, 1'b1, 1, 0, 1'b0);
    run_op(16'h0FFF, 16'h0001, 1'b0, 17'h00F00, 1'b1, 0, 0, 1'b0);
    run_op(16'h0FFF, 16'h0001, 1'b1, 17'h01000, 1'b1, 2, 0, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 17'h0FF00, 1'b1, 0, 0, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b1, 17'h10000, 1'b1, 2, 0, 1'b0);
    run_op(16'h8000, 16'h8000, 1'b1, 17'h10000, 1'b0, 0, 0, 1'b0);

    // Backpressure on the result port.
    run_op(16'h0FFF, 16'h0001, 1'b1, 17'h01000, 1'b1, 2, 5, 1'b0);

    // Reset in the middle of correction.
    sb_q.push_back('{sum: 17'h10000, err: 1'b1, fix: 2});
    @(negedge clk);
    a = 16'hFFFF; b = 16'h0001; exact = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #2;
    chk("mid_err", 32'(err), 32'd1);
    rst = 1'b1; #1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_sum", 32'(sum), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    chk("mid_rst_fix", 32'(fix_cnt), 32'd0);
    chk("mid_rst_ops", 32'(ops_cnt), 32'd0);
    chk("mid_rst_errc", 32'(err_cnt), 32'd0);
    sb_q.delete();
    exp_ops = 0; exp_errc = 0; s_ops = 0; s_errc = 0;
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("discarded", 32'(out_valid), 32'd0);

    // Clear coinciding with a completing handshake.
    run_op(16'h0001, 16'h0002, 1'b1, 17'h00003, 1'b0, 0, 0, 1'b0);
    run_op(16'h00FF, 16'h0001, 1'b0, 17'h00000, 1'b1, 0, 0, 1'b1);

    // Erroring operations drive the narrow counters into saturation.
    for (int i = 0; i < 18; i++) begin
      if (i % 2 == 0) run_op(16'h00FF, 16'h0001, 1'b0, 17'h00000, 1'b1, 0, 0, 1'b0);
      else            run_op(16'h00FF, 16'h0001, 1'b1, 17'h00100, 1'b1, 1, 0, 1'b0);
    end

    // Random operands against the reference model.
    for (int i = 0; i < 24; i++) begin
      rand_op(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
